// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider and its step logic.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Iteration counter width; one spare bit beyond the index range.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference only if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_sh_i,
  input  logic [WIDTH-1:0] d_reg_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic [WIDTH-1:0] q_next_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  logic           ge;

  // The extra top bit of t only takes part in the compare and the subtract.
  assign t    = {rem_i, q_sh_i[WIDTH-1]};
  assign ge   = (t >= {1'b0, d_reg_i});
  assign diff = t - {1'b0, d_reg_i};

  assign rem_next_o = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_next_o   = {q_sh_i[WIDTH-2:0], ge};

endmodule

// File: rtl/div_restoring.sv
// Multi-cycle restoring divider with single-shot valid handshake; EARLY_EXIT
// trades fixed latency for a one-edge finish on trivial operands.
module div_restoring
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH_DEFAULT,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             out_valid,
  output logic             div_by_zero
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] d_reg_q, d_reg_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i      (rem_q),
    .q_sh_i     (q_sh_q),
    .d_reg_i    (d_reg_q),
    .rem_next_o (step_rem),
    .q_next_o   (step_q)
  );

  assign in_ready = (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    d_reg_d     = d_reg_q;
    q_sh_d      = q_sh_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          d_reg_d = divisor;
          q_sh_d  = dividend;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (divisor == '0);
          state_d = S_CALC;
          // Divide-by-zero wins over the small-dividend shortcut.
          if (EARLY_EXIT != 0) begin
            if (divisor == '0) begin
              quotient_d  = '1;
              remainder_d = dividend;
              state_d     = S_DONE;
              out_valid_d = 1'b1;
            end else if (dividend < divisor) begin
              quotient_d  = '0;
              remainder_d = dividend;
              state_d     = S_DONE;
              out_valid_d = 1'b1;
            end
          end
        end
      end
      S_CALC: begin
        rem_d  = step_rem;
        q_sh_d = step_q;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quotient_d  = step_q;
          remainder_d = step_rem;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      d_reg_q     <= '0;
      q_sh_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_reg_q     <= d_reg_d;
      q_sh_q      <= q_sh_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_restoring.sv
// Scoreboard bench driving fixed- and early-exit divider instances in lockstep.
module tb_div_restoring;
  import div_pkg::*;

  localparam int W = DIV_WIDTH_DEFAULT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor  = '0;

  logic         in_ready0, out_valid0, dbz0;
  logic [W-1:0] quo0, rem0;
  logic         in_ready1, out_valid1, dbz1;
  logic [W-1:0] quo1, rem1;

  div_restoring #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .dividend(dividend), .divisor(divisor), .quotient(quo0), .remainder(rem0),
    .out_valid(out_valid0), .div_by_zero(dbz0)
  );

  div_restoring #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .dividend(dividend), .divisor(divisor), .quotient(quo1), .remainder(rem1),
    .out_valid(out_valid1), .div_by_zero(dbz1)
  );

  typedef struct {
    int unsigned  a;
    int unsigned  b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic score(input string who, input exp_t e, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic dbz, input int lat);
    $display("%s %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", who, e.a, e.b, q, r, dbz, lat);
    chk({who, "_quotient"}, 32'(q), 32'(e.q));
    chk({who, "_remainder"}, 32'(r), 32'(e.r));
    chk({who, "_dbz"}, 32'(dbz), 32'(e.dbz));
    chk({who, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  logic prev_ov0 = 1'b0;
  logic prev_ov1 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (out_valid0) begin
      chk("dut0_single_pulse", 32'(prev_ov0), 32'd0);
      if (sb0.size() == 0) chk("dut0_spurious_valid", 32'd1, 32'd0);
      else begin
        e = sb0.pop_front();
        score("dut0", e, quo0, rem0, dbz0, edge_cnt - e.acc + 1);
      end
    end
    prev_ov0 = out_valid0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid1) begin
      chk("dut1_single_pulse", 32'(prev_ov1), 32'd0);
      if (sb1.size() == 0) chk("dut1_spurious_valid", 32'd1, 32'd0);
      else begin
        e = sb1.pop_front();
        score("dut1", e, quo1, rem1, dbz1, edge_cnt - e.acc + 1);
      end
    end
    prev_ov1 = out_valid1;
  end

  // Expected results come from plain integer division, not the step logic.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    e.a   = 32'(a);
    e.b   = 32'(b);
    e.q   = (b == '0) ? {W{1'b1}} : a / b;
    e.r   = (b == '0) ? a : a % b;
    e.dbz = (b == '0);
    e.acc = acc;
    e.lat = W + 1;
    sb0.push_back(e);
    e.lat = ((b == '0) || (a < b)) ? 1 : W + 1;
    sb1.push_back(e);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!(in_ready0 && in_ready1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
      if (sb0.size() != 0) chk("dut0_busy_in_ready", 32'(in_ready0), 32'd0);
      if (sb1.size() != 0) chk("dut1_busy_in_ready", 32'(in_ready1), 32'd0);
    end
    if (guard >= 100) chk("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    wait_ready();
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    push(a, b, edge_cnt + 1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic hold_test();
    int acc0;
    int guard = 0;
    @(negedge clk);
    wait_ready();
    dividend = 4'd9;
    divisor  = 4'd2;
    in_valid = 1'b1;
    acc0 = edge_cnt + 1;
    push(4'd9, 4'd2, acc0);
    @(negedge clk);
    dividend = 4'd15;
    divisor  = 4'd1;
    while (!in_ready0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("hold_timeout", 32'd0, 32'd1);
    chk("hold_dut1_ready", 32'(in_ready1), 32'd1);
    chk("hold_accept_edge", 32'(edge_cnt + 1), 32'(acc0 + W + 2));
    push(4'd15, 4'd1, edge_cnt + 1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic reset_test();
    @(negedge clk);
    wait_ready();
    dividend = 4'd14;
    divisor  = 4'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_quotient0", 32'(quo0), 32'd0);
    chk("rst_mid_remainder0", 32'(rem0), 32'd0);
    chk("rst_mid_dbz0", 32'(dbz0), 32'd0);
    chk("rst_mid_valid0", 32'(out_valid0), 32'd0);
    chk("rst_mid_quotient1", 32'(quo1), 32'd0);
    chk("rst_mid_remainder1", 32'(rem1), 32'd0);
    chk("rst_mid_ready0", 32'(in_ready0), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready0", 32'(in_ready0), 32'd1);
    chk("rst_rel_ready1", 32'(in_ready1), 32'd1);
    repeat (W + 4) @(negedge clk);
    do_op(4'd6, 4'd2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_quotient", 32'(quo0), 32'd0);
    chk("reset_remainder", 32'(rem0), 32'd0);
    chk("reset_out_valid", 32'(out_valid0), 32'd0);
    chk("reset_dbz", 32'(dbz0), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready0), 32'd1);

    do_op(4'd13, 4'd3);
    do_op(4'd7, 4'd0);
    do_op(4'd2, 4'd5);
    do_op(4'd15, 4'd1);
    do_op(4'd0, 4'd0);
    hold_test();
    do_op(4'd15, 4'd4);
    do_op(4'd8, 4'd8);
    reset_test();
    for (int i = 0; i < 8; i++) begin
      do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
